// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush controller for a 5-stage in-order core
//
// Purpose:
//   Decides, each cycle, which pipeline registers hold (stall) or clear (flush)
//   based on load-use hazards, taken branches, instruction-fetch wait, data-memory
//   wait, multi-cycle multiply/divide and traps. A small FSM covers the
//   multi-cycle waits; all control outputs are combinational from state + inputs.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   id_valid, id_rs1, id_rs2,
//   id_uses_rs1, id_uses_rs2          ID-stage instruction and its source regs
//   ex_valid, ex_rd, ex_mem_read,
//   ex_mul_start, ex_div_start,
//   branch_taken_ex                   EX-stage instruction and its events
//   div_done                          divider finished
//   imem_ready                        instruction memory has data this cycle
//   dmem_req, dmem_ready              data memory request / completion
//   trap_req                          trap entry request
//   pc_stall .. exmem_flush           per-register stall/flush controls
//   mul_done                          multiply result available (one cycle)
//   div_abort                         cancel the in-flight divide
//   trap_ack                          trap taken this cycle
//   state_out                         current FSM state encoding
//   stall_count                       cycles with pc_stall=1 (wraps)

module pipeline_hazard_ctrl #(
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,

   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_mul_start,
   input  logic        ex_div_start,
   input  logic        branch_taken_ex,

   input  logic        div_done,
   input  logic        imem_ready,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   input  logic        trap_req,

   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        idex_stall,
   output logic        idex_flush,
   output logic        exmem_stall,
   output logic        exmem_flush,
   output logic        mul_done,
   output logic        div_abort,
   output logic        trap_ack,

   output logic [2:0]  state_out,
   output logic [31:0] stall_count
);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      MUL_WAIT = 3'd1,
      DIV_WAIT = 3'd2,
      MEM_WAIT = 3'd3
   } state_t;

   // Counter starts at MUL_CYCLES-1 so MUL_WAIT lasts exactly MUL_CYCLES cycles,
   // the last of which reports mul_done.
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   state_t     state;
   state_t     state_nx;
   logic [3:0] mul_cnt;
   logic [3:0] mul_cnt_nx;

   // Raw requests before stall/flush conflict resolution and reset gating.
   logic pc_stall_req;
   logic ifid_stall_req;
   logic ifid_flush_req;
   logic idex_stall_req;
   logic idex_flush_req;
   logic exmem_stall_req;
   logic exmem_flush_req;
   logic mul_done_req;
   logic div_abort_req;
   logic trap_ack_req;

   logic load_use;
   logic mem_wait;

   assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));

   assign mem_wait = dmem_req & ~dmem_ready;

   always_comb begin
      state_nx        = state;
      mul_cnt_nx      = mul_cnt;
      pc_stall_req    = 1'b0;
      ifid_stall_req  = 1'b0;
      ifid_flush_req  = 1'b0;
      idex_stall_req  = 1'b0;
      idex_flush_req  = 1'b0;
      exmem_stall_req = 1'b0;
      exmem_flush_req = 1'b0;
      mul_done_req    = 1'b0;
      div_abort_req   = 1'b0;
      trap_ack_req    = 1'b0;

      case (state)
         RUN: begin
            if (trap_req) begin
               ifid_flush_req  = 1'b1;
               idex_flush_req  = 1'b1;
               exmem_flush_req = 1'b1;
               trap_ack_req    = 1'b1;
            end else if (mem_wait) begin
               // Freeze the whole front of the pipe; nothing may advance into MEM.
               pc_stall_req    = 1'b1;
               ifid_stall_req  = 1'b1;
               idex_stall_req  = 1'b1;
               exmem_stall_req = 1'b1;
               state_nx        = MEM_WAIT;
            end else if (ex_mul_start) begin
               // Hold the multiply in EX and feed a bubble into MEM meanwhile.
               pc_stall_req    = 1'b1;
               ifid_stall_req  = 1'b1;
               idex_stall_req  = 1'b1;
               exmem_flush_req = 1'b1;
               mul_cnt_nx      = MUL_LOAD;
               state_nx        = MUL_WAIT;
            end else if (ex_div_start) begin
               pc_stall_req    = 1'b1;
               ifid_stall_req  = 1'b1;
               idex_stall_req  = 1'b1;
               exmem_flush_req = 1'b1;
               state_nx        = DIV_WAIT;
            end else if (branch_taken_ex) begin
               // Wrong-path instructions in IF/ID and ID/EX die; PC must move
               // to the target, so it is never stalled here.
               ifid_flush_req  = 1'b1;
               idex_flush_req  = 1'b1;
            end else begin
               if (load_use) begin
                  pc_stall_req   = 1'b1;
                  ifid_stall_req = 1'b1;
                  idex_flush_req = 1'b1;
               end
               if (!imem_ready) begin
                  pc_stall_req   = 1'b1;
                  ifid_flush_req = 1'b1;
               end
            end
         end

         MUL_WAIT: begin
            if (trap_req) begin
               ifid_flush_req  = 1'b1;
               idex_flush_req  = 1'b1;
               exmem_flush_req = 1'b1;
               trap_ack_req    = 1'b1;
               mul_cnt_nx      = 4'd0;
               state_nx        = RUN;
            end else if (mul_cnt != 4'd0) begin
               pc_stall_req    = 1'b1;
               ifid_stall_req  = 1'b1;
               idex_stall_req  = 1'b1;
               exmem_flush_req = 1'b1;
               mul_cnt_nx      = mul_cnt - 4'd1;
            end else begin
               mul_done_req    = 1'b1;
               state_nx        = RUN;
            end
         end

         DIV_WAIT: begin
            if (trap_req) begin
               ifid_flush_req  = 1'b1;
               idex_flush_req  = 1'b1;
               exmem_flush_req = 1'b1;
               trap_ack_req    = 1'b1;
               div_abort_req   = 1'b1;
               state_nx        = RUN;
            end else if (!div_done) begin
               pc_stall_req    = 1'b1;
               ifid_stall_req  = 1'b1;
               idex_stall_req  = 1'b1;
               exmem_flush_req = 1'b1;
            end else begin
               state_nx        = RUN;
            end
         end

         MEM_WAIT: begin
            // A pending memory access cannot be cancelled, so a trap is only
            // taken once the access completes.
            if (!dmem_ready) begin
               pc_stall_req    = 1'b1;
               ifid_stall_req  = 1'b1;
               idex_stall_req  = 1'b1;
               exmem_stall_req = 1'b1;
            end else begin
               state_nx = RUN;
               if (trap_req) begin
                  ifid_flush_req  = 1'b1;
                  idex_flush_req  = 1'b1;
                  exmem_flush_req = 1'b1;
                  trap_ack_req    = 1'b1;
               end
            end
         end

         default: begin
            state_nx   = RUN;
            mul_cnt_nx = 4'd0;
         end
      endcase
   end

   // A flush wins over a stall on the same register; reset forces all low.
   assign pc_stall    = reset_n & pc_stall_req;
   assign ifid_stall  = reset_n & ifid_stall_req & ~ifid_flush_req;
   assign ifid_flush  = reset_n & ifid_flush_req;
   assign idex_stall  = reset_n & idex_stall_req & ~idex_flush_req;
   assign idex_flush  = reset_n & idex_flush_req;
   assign exmem_stall = reset_n & exmem_stall_req & ~exmem_flush_req;
   assign exmem_flush = reset_n & exmem_flush_req;
   assign mul_done    = reset_n & mul_done_req;
   assign div_abort   = reset_n & div_abort_req;
   assign trap_ack    = reset_n & trap_ack_req;

   assign state_out   = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RUN;
         mul_cnt     <= 4'd0;
         stall_count <= 32'd0;
      end else begin
         state       <= state_nx;
         mul_cnt     <= mul_cnt_nx;
         stall_count <= stall_count + {31'd0, pc_stall};
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl

module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        reset_n;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        ex_mul_start;
   logic        ex_div_start;
   logic        branch_taken_ex;
   logic        div_done;
   logic        imem_ready;
   logic        dmem_req;
   logic        dmem_ready;
   logic        trap_req;
   logic        pc_stall;
   logic        ifid_stall;
   logic        ifid_flush;
   logic        idex_stall;
   logic        idex_flush;
   logic        exmem_stall;
   logic        exmem_flush;
   logic        mul_done;
   logic        div_abort;
   logic        trap_ack;
   logic [2:0]  state_out;
   logic [31:0] stall_count;

   pipeline_hazard_ctrl #(.MUL_CYCLES(4)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_valid        (ex_valid),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_mul_start    (ex_mul_start),
      .ex_div_start    (ex_div_start),
      .branch_taken_ex (branch_taken_ex),
      .div_done        (div_done),
      .imem_ready      (imem_ready),
      .dmem_req        (dmem_req),
      .dmem_ready      (dmem_ready),
      .trap_req        (trap_req),
      .pc_stall        (pc_stall),
      .ifid_stall      (ifid_stall),
      .ifid_flush      (ifid_flush),
      .idex_stall      (idex_stall),
      .idex_flush      (idex_flush),
      .exmem_stall     (exmem_stall),
      .exmem_flush     (exmem_flush),
      .mul_done        (mul_done),
      .div_abort       (div_abort),
      .trap_ack        (trap_ack),
      .state_out       (state_out),
      .stall_count     (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush
   //                   exmem_stall exmem_flush mul_done div_abort trap_ack
   logic [9:0] outs;
   assign outs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                  exmem_stall, exmem_flush, mul_done, div_abort, trap_ack};

   localparam logic [9:0] O_NONE  = 10'b0000000000;
   localparam logic [9:0] O_LU    = 10'b1100100000;
   localparam logic [9:0] O_BR    = 10'b0010100000;
   localparam logic [9:0] O_IMEM  = 10'b1010000000;
   localparam logic [9:0] O_LUIM  = 10'b1010100000;
   localparam logic [9:0] O_TRAP  = 10'b0010101001;
   localparam logic [9:0] O_TRDIV = 10'b0010101011;
   localparam logic [9:0] O_MC    = 10'b1101001000;
   localparam logic [9:0] O_MEM   = 10'b1101010000;
   localparam logic [9:0] O_MDONE = 10'b0000000100;

   typedef struct packed {
      logic       iv;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       ev;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic       imr;
      logic       dreq;
      logic       drdy;
      logic       trap;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs [14];

   int n_cmp;
   int n_bad;
   int exp_sc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic idle_inputs();
      id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_valid = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_mul_start = 1'b0;
      ex_div_start = 1'b0; branch_taken_ex = 1'b0; div_done = 1'b0;
      imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1; trap_req = 1'b0;
   endtask

   // Check one cycle at the falling edge, then advance past the rising edge.
   task automatic step(input string name, input logic [2:0] st, input logic [9:0] exp);
      @(negedge clk);
      chk({name, " outs"}, {22'd0, outs}, {22'd0, exp});
      chk({name, " state"}, {29'd0, state_out}, {29'd0, st});
      chk({name, " stall_count"}, stall_count, exp_sc);
      if (exp[9]) exp_sc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      exp_sc = 0;

      //           iv    rs1   rs2   u1    u2    ev    rd    mr    br    imr   dreq  drdy  trap  exp
      vecs[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_NONE};
      vecs[1]  = '{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_LU};
      vecs[2]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_NONE};
      vecs[3]  = '{1'b1, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_NONE};
      vecs[4]  = '{1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_LU};
      vecs[5]  = '{1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_NONE};
      vecs[6]  = '{1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_NONE};
      vecs[7]  = '{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_BR};
      vecs[8]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_IMEM};
      vecs[9]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_BR};
      vecs[10] = '{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_LUIM};
      vecs[11] = '{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_TRAP};
      vecs[12] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, O_TRAP};
      vecs[13] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_NONE};

      // Reset: outputs low even with a would-be stall on the inputs.
      idle_inputs();
      imem_ready = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset outs", {22'd0, outs}, 32'd0);
      chk("reset state", {29'd0, state_out}, 32'd0);
      chk("reset stall_count", stall_count, 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      reset_n = 1'b1;

      // Single-cycle RUN behaviour; every vector leaves the FSM in RUN.
      for (int i = 0; i < 14; i++) begin
         id_valid = vecs[i].iv; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
         id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
         ex_valid = vecs[i].ev; ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mr;
         branch_taken_ex = vecs[i].br; imem_ready = vecs[i].imr;
         dmem_req = vecs[i].dreq; dmem_ready = vecs[i].drdy; trap_req = vecs[i].trap;
         step($sformatf("vec%0d", i), 3'd0, vecs[i].exp);
      end
      idle_inputs();
      step("after vectors", 3'd0, O_NONE);

      // Multiply: entry cycle, 3 counting cycles, then mul_done.
      ex_valid = 1'b1;
      ex_mul_start = 1'b1;
      step("mul entry", 3'd0, O_MC);
      for (int c = 1; c <= 3; c++) step($sformatf("mul wait%0d", c), 3'd1, O_MC);
      step("mul done", 3'd1, O_MDONE);
      idle_inputs();
      step("mul back", 3'd0, O_NONE);

      // Divide completing normally.
      ex_valid = 1'b1;
      ex_div_start = 1'b1;
      step("div entry", 3'd0, O_MC);
      step("div wait", 3'd2, O_MC);
      div_done = 1'b1;
      step("div done", 3'd2, O_NONE);
      idle_inputs();
      step("div back", 3'd0, O_NONE);

      // Divide aborted by a trap on the third DIV_WAIT cycle.
      ex_valid = 1'b1;
      ex_div_start = 1'b1;
      step("divtrap entry", 3'd0, O_MC);
      step("divtrap wait1", 3'd2, O_MC);
      step("divtrap wait2", 3'd2, O_MC);
      trap_req = 1'b1;
      step("divtrap trap", 3'd2, O_TRDIV);
      idle_inputs();
      step("divtrap back", 3'd0, O_NONE);

      // Memory wait with a trap held high: trap waits for dmem_ready.
      dmem_req = 1'b1;
      dmem_ready = 1'b0;
      step("mem entry", 3'd0, O_MEM);
      trap_req = 1'b1;
      for (int c = 1; c <= 5; c++) step($sformatf("mem wait%0d", c), 3'd3, O_MEM);
      dmem_ready = 1'b1;
      step("mem trap", 3'd3, O_TRAP);
      idle_inputs();
      step("mem back", 3'd0, O_NONE);

      // Reset in the middle of a multiply abandons it.
      ex_valid = 1'b1;
      ex_mul_start = 1'b1;
      step("mulrst entry", 3'd0, O_MC);
      step("mulrst wait", 3'd1, O_MC);
      imem_ready = 1'b0;
      reset_n = 1'b0;
      #2;
      exp_sc = 0;
      chk("mulrst outs", {22'd0, outs}, 32'd0);
      chk("mulrst state", {29'd0, state_out}, 32'd0);
      chk("mulrst stall_count", stall_count, 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      reset_n = 1'b1;
      // First edge after reset is evaluated in RUN: a load-use stalls one cycle.
      id_valid = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      ex_valid = 1'b1; ex_rd = 5'd5; ex_mem_read = 1'b1;
      step("post reset lu", 3'd0, O_LU);
      idle_inputs();
      step("post reset idle", 3'd0, O_NONE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, EX-stage multiply latency in cycles; legal range 2..15.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have inputs id_valid 1, id_rs1 5, id_rs2 5, id_uses_rs1 1, id_uses_rs2 1: the ID-stage instruction and its source registers.
REQ-005 SHALL have inputs ex_valid 1, ex_rd 5, ex_mem_read 1, ex_mul_start 1, ex_div_start 1, branch_taken_ex 1: the EX-stage instruction and its events.
REQ-006 SHALL have inputs div_done 1, imem_ready 1, dmem_req 1, dmem_ready 1, trap_req 1.
REQ-007 SHALL have outputs pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, exmem_flush, mul_done, div_abort, trap_ack, each 1 bit.
REQ-008 SHALL have outputs state_out 3 (current FSM state encoding) and stall_count 32 (performance counter).

Function
REQ-009 SHALL implement FSM states RUN=0, MUL_WAIT=1, DIV_WAIT=2, MEM_WAIT=3.
REQ-010 All stall, flush, mul_done, div_abort and trap_ack outputs SHALL be combinational from the current state and inputs, taking effect in the same cycle.
REQ-011 Load-use in RUN SHALL be ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). It SHALL assert pc_stall, ifid_stall and idex_flush for that cycle, with no state change.
REQ-012 Branch in RUN: branch_taken_ex SHALL assert ifid_flush and idex_flush. It SHALL suppress load-use and imem stall outputs and SHALL deassert pc_stall.
REQ-013 imem_ready=0 in RUN without a branch SHALL assert pc_stall and ifid_flush.
REQ-014 Mem-wait entry: in RUN, dmem_req & !dmem_ready SHALL assert pc_stall, ifid_stall, idex_stall and exmem_stall with no flushes. Next state SHALL be MEM_WAIT. This has priority over REQ-011 to REQ-016.
REQ-015 Multiply entry: in RUN, ex_mul_start (with no mem-wait) SHALL load the counter with MUL_CYCLES-1, go to MUL_WAIT, and assert pc_stall, ifid_stall, idex_stall and exmem_flush.
REQ-016 Divide entry: in RUN, ex_div_start (with no mem-wait and no mul start) SHALL go to DIV_WAIT with the same outputs as REQ-015.
REQ-017 MUL_WAIT SHALL decrement the counter each cycle.
- Counter !=0: assert REQ-015 outputs.
- Counter ==0: assert mul_done for one cycle, assert no stalls, and go to RUN.
REQ-018 DIV_WAIT SHALL assert REQ-015 outputs while div_done=0. When div_done=1 it SHALL assert no stalls and go to RUN.
REQ-019 MEM_WAIT SHALL assert the REQ-014 outputs while dmem_ready=0. When dmem_ready=1 it SHALL assert no stalls and go to RUN.
REQ-020 EX inputs SHALL be held by the stalls; ex_mul_start or ex_div_start still high on return to RUN SHALL be re-evaluated normally.
REQ-021 Trap in RUN, MUL_WAIT or DIV_WAIT: trap_req SHALL assert ifid_flush, idex_flush, exmem_flush and trap_ack, and SHALL deassert all stalls. Next state SHALL be RUN. In DIV_WAIT it SHALL also assert div_abort. trap_req SHALL override all other rules.
REQ-022 Trap in MEM_WAIT: trap_req SHALL be ignored (trap_ack=0) until the dmem_ready cycle. In that cycle REQ-021 SHALL apply.
REQ-023 stall_count SHALL increment by 1 every cycle pc_stall=1, wrapping from 0xFFFFFFFF to 0.
REQ-024 Any stall and flush asserted together on the same register SHALL resolve to flush only (stall deasserted).

Reset
REQ-025 While reset_n=0: state SHALL be RUN, the counter SHALL be 0, stall_count SHALL be 0, and all 1-bit outputs SHALL be 0. Reset mid-MUL/DIV/MEM SHALL abandon the operation.
REQ-026 The first edge after reset_n rises SHALL evaluate in RUN.

Verification
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_stall=ifid_stall=idex_flush=1; stall_count=1.
- Load-use with ex_rd=0 -> no stall; branch_taken_ex together with a load-use -> ifid_flush=idex_flush=1, pc_stall=0.
- Multiply: ex_mul_start held, MUL_CYCLES=4 -> stalls for cycles 1-3; cycle 4 mul_done=1 with no stall; state_out returns to 0.
- Divide plus trap: ex_div_start, then trap_req on the 3rd DIV_WAIT cycle -> trap_ack=div_abort=1, all three flushes=1, next state RUN.
- Memory plus trap: dmem_req=1 with dmem_ready=0 for 5 cycles and trap_req high throughout -> 5 cycles of 4-way stall with trap_ack=0; dmem_ready cycle -> trap_ack=1.
- Reset in MUL_WAIT: reset_n low -> all outputs 0, state_out=0, stall_count=0.
